// File: rtl/pc_pkg.sv
// Shared types and helpers for the rv32i fetch-stage program-counter generator.
package pc_pkg;

    // Widest address bus the alignment helper has to look at.
    localparam int unsigned MAX_XLEN = 64;

    typedef enum logic {
        PC_RUN,
        PC_HALT
    } pc_state_e;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_BRJ,
        RD_TRAP
    } redirect_src_e;

    // True when the low align_bits bits of addr are all zero.
    function automatic logic is_aligned(input logic [MAX_XLEN-1:0] addr,
                                        input int unsigned align_bits);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_XLEN; i++) begin
            if ((i < align_bits) && addr[i]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: trap beats jump/branch; a misaligned
// jump/branch target is diverted to the trap vector.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic            trap_e,
    input  logic            jpe,
    input  logic            brch_e,
    input  logic [XLEN-1:0] jmp,
    input  logic [XLEN-1:0] trap_vec,
    output logic            redirect_en,
    output logic [XLEN-1:0] redirect_target,
    output logic            misalign_det
);

    redirect_src_e src;
    logic          jmp_aligned;

    assign jmp_aligned = is_aligned(MAX_XLEN'(jmp), ALIGN_BITS);

    // Pick the winning redirect source for this cycle.
    always_comb begin
        src = RD_NONE;
        if (trap_e) begin
            src = RD_TRAP;
        end else if (jpe || brch_e) begin
            src = RD_BRJ;
        end
    end

    // Resolve the target; a misaligned jump lands on the trap vector instead.
    always_comb begin
        redirect_en     = 1'b0;
        redirect_target = trap_vec;
        misalign_det    = 1'b0;
        case (src)
            RD_TRAP: begin
                redirect_en     = 1'b1;
                redirect_target = trap_vec;
            end
            RD_BRJ: begin
                redirect_en = 1'b1;
                if (jmp_aligned) begin
                    redirect_target = jmp;
                end else begin
                    redirect_target = trap_vec;
                    misalign_det    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: fetch handshake, stall, prioritised redirects,
// misaligned-target diversion and a debug halt/resume state machine.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int unsigned     INC        = 4,
    parameter int unsigned     ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [XLEN-1:0] jmp,
    input  logic            jpe,
    input  logic            brch_e,
    input  logic            trap_e,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            if_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr,
    output logic            halted
);

    localparam logic [XLEN-1:0] IncW      = XLEN'(INC);
    localparam logic [XLEN-1:0] ResetNext = RESET_VEC + IncW;

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_next_q, pc_next_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

    logic            redirect_en;
    logic [XLEN-1:0] redirect_target;
    logic            misalign_det;
    logic            advance;

    pc_redirect_arb #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_arb (
        .trap_e          (trap_e),
        .jpe             (jpe),
        .brch_e          (brch_e),
        .jmp             (jmp),
        .trap_vec        (trap_vec),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .misalign_det    (misalign_det)
    );

    // A sequential step only happens when the current fetch is accepted.
    assign advance = (state_q == PC_RUN) && if_ready && !stall;

    // Next pc/pc_next: redirects win over stall and handshake, then advance, else hold.
    always_comb begin
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        if (redirect_en) begin
            pc_d      = redirect_target;
            pc_next_d = redirect_target + IncW;
        end else if (advance) begin
            pc_d      = pc_next_q;
            pc_next_d = pc_next_q + IncW;
        end
    end

    // Misalign pulse and sticky offending address.
    always_comb begin
        misalign_d      = misalign_det;
        misalign_addr_d = misalign_addr_q;
        if (misalign_det) begin
            misalign_addr_d = jmp;
        end
    end

    // Halt/resume FSM; a trap always forces RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PC_RUN: begin
                if (halt_req && !trap_e) begin
                    state_d = PC_HALT;
                end
            end
            PC_HALT: begin
                if (resume || trap_e) begin
                    state_d = PC_RUN;
                end
            end
            default: state_d = PC_RUN;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= PC_RUN;
            pc_q            <= RESET_VEC;
            pc_next_q       <= ResetNext;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_next_q       <= pc_next_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    // Output drive; if_valid drops immediately while reset is held.
    always_comb begin
        if_valid      = (state_q == PC_RUN) && !reset;
        pc            = pc_q;
        pc_next       = pc_next_q;
        misalign      = misalign_q;
        misalign_addr = misalign_addr_q;
        halted        = (state_q == PC_HALT);
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (ALIGN_BITS=2 and ALIGN_BITS=1) share stimulus;
// a behavioural model is compared every cycle, plus hand-computed literal checks.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall, jpe, brch_e, trap_e, halt_req, resume, if_ready;
    logic [31:0] jmp, trap_vec;

    logic        if_valid_o[2];
    logic [31:0] pc_o[2];
    logic [31:0] pc_next_o[2];
    logic        misalign_o[2];
    logic [31:0] misalign_addr_o[2];
    logic        halted_o[2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .INC(4), .ALIGN_BITS(2)) u_a (
        .clk(clk), .reset(reset), .stall(stall), .jmp(jmp), .jpe(jpe), .brch_e(brch_e),
        .trap_e(trap_e), .trap_vec(trap_vec), .halt_req(halt_req), .resume(resume),
        .if_ready(if_ready), .if_valid(if_valid_o[0]), .pc(pc_o[0]), .pc_next(pc_next_o[0]),
        .misalign(misalign_o[0]), .misalign_addr(misalign_addr_o[0]), .halted(halted_o[0])
    );

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .INC(4), .ALIGN_BITS(1)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .jmp(jmp), .jpe(jpe), .brch_e(brch_e),
        .trap_e(trap_e), .trap_vec(trap_vec), .halt_req(halt_req), .resume(resume),
        .if_ready(if_ready), .if_valid(if_valid_o[1]), .pc(pc_o[1]), .pc_next(pc_next_o[1]),
        .misalign(misalign_o[1]), .misalign_addr(misalign_addr_o[1]), .halted(halted_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pc only; pc_next is always pc+4 by construction.
    logic [31:0] amask[2] = '{32'h3, 32'h1};
    logic [31:0] m_pc[2]    = '{32'h0, 32'h0};
    logic [31:0] m_maddr[2] = '{32'h0, 32'h0};
    bit          m_halt[2]  = '{1'b0, 1'b0};
    bit          m_mis[2]   = '{1'b0, 1'b0};
    bit          started = 1'b0;
    bit          bad, was_halt;

    always @(posedge clk) begin
        started = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_pc[k]    = 32'h0;
                m_halt[k]  = 1'b0;
                m_mis[k]   = 1'b0;
                m_maddr[k] = 32'h0;
            end else begin
                was_halt = m_halt[k];
                bad = !trap_e && (jpe || brch_e) && ((jmp & amask[k]) != 0);
                if (trap_e)               m_pc[k] = trap_vec;
                else if (jpe || brch_e)   m_pc[k] = bad ? trap_vec : jmp;
                else if (!was_halt && if_ready && !stall) m_pc[k] = m_pc[k] + 32'd4;
                if (was_halt) m_halt[k] = !(resume || trap_e);
                else          m_halt[k] = halt_req && !trap_e;
                m_mis[k] = bad;
                if (bad) m_maddr[k] = jmp;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.pc", k), pc_o[k], m_pc[k]);
                chk($sformatf("u%0d.pc_next", k), pc_next_o[k], m_pc[k] + 32'd4);
                chk($sformatf("u%0d.if_valid", k), 32'(if_valid_o[k]),
                    32'(!m_halt[k] && !reset));
                chk($sformatf("u%0d.halted", k), 32'(halted_o[k]), 32'(m_halt[k]));
                chk($sformatf("u%0d.misalign", k), 32'(misalign_o[k]), 32'(m_mis[k]));
                chk($sformatf("u%0d.misalign_addr", k), misalign_addr_o[k], m_maddr[k]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; jpe = 1'b0; brch_e = 1'b0; trap_e = 1'b0;
        halt_req = 1'b0; resume = 1'b0; if_ready = 1'b1;
        jmp = 32'h0; trap_vec = 32'h80;
        step(2);
        chk("reset_pc", pc_o[0], 32'h0);
        chk("reset_pc_next", pc_next_o[0], 32'h4);
        chk("reset_halted", 32'(halted_o[0]), 32'h0);

        // Sequential fetch
        reset = 1'b0;
        step(1); chk("seq_pc4", pc_o[0], 32'h4);
        step(1); chk("seq_pc8", pc_o[0], 32'h8);

        // if_ready low, then stall high
        if_ready = 1'b0; step(3); chk("notready_hold", pc_o[0], 32'h8);
        if_ready = 1'b1; step(1); chk("ready_adv", pc_o[0], 32'hC);
        stall = 1'b1;    step(3); chk("stall_hold", pc_o[0], 32'hC);
        stall = 1'b0;    step(1); chk("stall_rel", pc_o[0], 32'h10);

        // Trap beats jump; jump taken under stall
        jpe = 1'b1; jmp = 32'h100; trap_e = 1'b1; trap_vec = 32'h200;
        step(1);
        chk("trap_prio_pc", pc_o[0], 32'h200);
        chk("trap_prio_next", pc_next_o[0], 32'h204);
        trap_e = 1'b0; stall = 1'b1;
        step(1); chk("jump_stall_pc", pc_o[0], 32'h100);

        // Misaligned branch: diverted with ALIGN_BITS=2, accepted with ALIGN_BITS=1
        jpe = 1'b0; stall = 1'b0; trap_vec = 32'h80; brch_e = 1'b1; jmp = 32'h102;
        step(1);
        chk("mis_a_pc", pc_o[0], 32'h80);
        chk("mis_a_pulse", 32'(misalign_o[0]), 32'h1);
        chk("mis_a_addr", misalign_addr_o[0], 32'h102);
        chk("mis_b_pc", pc_o[1], 32'h102);
        chk("mis_b_pulse", 32'(misalign_o[1]), 32'h0);
        brch_e = 1'b0;
        step(1);
        chk("mis_a_drop", 32'(misalign_o[0]), 32'h0);
        chk("mis_a_hold_addr", misalign_addr_o[0], 32'h102);

        // Halt / resume
        jpe = 1'b1; jmp = 32'h1C; step(1); jpe = 1'b0;
        halt_req = 1'b1; step(1);
        chk("halt_pc", pc_o[0], 32'h20);
        chk("halt_flag", 32'(halted_o[0]), 32'h1);
        chk("halt_ifvalid", 32'(if_valid_o[0]), 32'h0);
        step(4); chk("halt_hold", pc_o[0], 32'h20);
        halt_req = 1'b0; resume = 1'b1; step(1);
        chk("resume_flag", 32'(halted_o[0]), 32'h0);
        resume = 1'b0; step(1); chk("resume_adv", pc_o[0], 32'h24);
        halt_req = 1'b1; step(1); chk("halt2_pc", pc_o[0], 32'h28);
        resume = 1'b1; step(1); chk("resume_win", 32'(halted_o[0]), 32'h0);
        resume = 1'b0; step(1);
        chk("rehalt_flag", 32'(halted_o[0]), 32'h1);
        chk("rehalt_pc", pc_o[0], 32'h2C);
        halt_req = 1'b0; trap_e = 1'b1; trap_vec = 32'h200; step(1);
        chk("trap_halt_pc", pc_o[0], 32'h200);
        chk("trap_halt_flag", 32'(halted_o[0]), 32'h0);
        trap_e = 1'b0; halt_req = 1'b1; jpe = 1'b1; jmp = 32'h300; step(1);
        chk("halt_jump_pc", pc_o[0], 32'h300);
        chk("halt_jump_flag", 32'(halted_o[0]), 32'h1);
        halt_req = 1'b0; jmp = 32'h40; step(1);
        chk("jump_in_halt_pc", pc_o[0], 32'h40);
        chk("jump_in_halt_flag", 32'(halted_o[0]), 32'h1);
        jpe = 1'b0; resume = 1'b1; step(1); resume = 1'b0;

        // Wrap at the top of the address space
        jpe = 1'b1; jmp = 32'hFFFF_FFFC; step(1);
        chk("wrap_pc", pc_o[0], 32'hFFFF_FFFC);
        chk("wrap_next", pc_next_o[0], 32'h0);
        jpe = 1'b0; step(1); chk("wrap_pc0", pc_o[0], 32'h0);
        step(1);
        // Reset while stalled
        stall = 1'b1; step(2); chk("stall_pc4", pc_o[0], 32'h4);
        reset = 1'b1; step(1);
        chk("reset_mid_pc", pc_o[0], 32'h0);
        chk("reset_mid_next", pc_next_o[0], 32'h4);
        reset = 1'b0; stall = 1'b0; step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the rv32i fetch stage. It is the successor to the basic PC register. It adds:
- a valid/ready fetch handshake and a stall input;
- prioritised redirects (trap > jump/branch);
- a misaligned-target check that diverts to the trap vector;
- a halt/resume state machine for debug.

It sits between the branch/jump unit, the trap logic and the instruction-memory port.

Parameters:
XLEN, 32, width of pc, pc_next and all target/vector buses
RESET_VEC, 32'h0000_0000, value of pc after reset; pc_next resets to RESET_VEC+INC
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, number of target LSBs that must be zero (2 = no C-ext, 1 = C-ext)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  freezes sequential advance; redirects are still taken
jmp  in  XLEN  jump/branch target
jpe  in  1  jump taken
brch_e  in  1  branch taken
trap_e  in  1  trap/interrupt redirect
trap_vec  in  XLEN  trap target (assumed aligned by CSR logic)
halt_req  in  1  debug halt request (level)
resume  in  1  debug resume pulse
if_ready  in  1  instruction memory accepts the current pc
if_valid  out  1  pc is a valid fetch address
pc  out  XLEN  current fetch address
pc_next  out  XLEN  pc+INC, registered
misalign  out  1  one-cycle pulse: a redirect target was misaligned
misalign_addr  out  XLEN  offending target, held until the next misalign
halted  out  1  high in HALT state

Behaviour:
- Reset values (synchronous, dominates all other inputs, including mid-transaction):
  - pc=RESET_VEC, pc_next=RESET_VEC+INC;
  - state=RUN, misalign=0, misalign_addr=0, halted=0.
- if_valid = (state==RUN) & ~reset. The output is combinational from the state register.
- Redirect priority, evaluated every cycle:
  - trap_e first;
  - then (jpe|brch_e);
  - else sequential advance.
- Trap redirect: pc<=trap_vec, pc_next<=trap_vec+INC. Taken in any state; forces state to RUN.
- Jump/branch redirect:
  - If jmp[ALIGN_BITS-1:0]==0: pc<=jmp, pc_next<=jmp+INC.
  - Otherwise: pc<=trap_vec, pc_next<=trap_vec+INC, misalign=1 for 1 cycle, misalign_addr<=jmp.
  - Taken regardless of stall or if_ready: a redirect flushes the outstanding fetch.
  - In HALT, pc is updated but state stays HALT.
- Sequential advance requires state==RUN & if_ready & ~stall. Then pc<=pc_next, pc_next<=pc_next+INC. Otherwise pc and pc_next hold.
- Latency: a redirect asserted in cycle N makes pc equal the target in cycle N+1. There is no bubble beyond that cycle.
- Arithmetic: unsigned, modulo 2^XLEN. pc_next wraps from 2^XLEN-INC to 0 without a flag.
- FSM (2 states):
  - RUN -> HALT when halt_req=1 and no trap_e that cycle. pc holds at the next unfetched address.
  - HALT -> RUN on resume=1 or trap_e=1.
  - halt_req and resume both high in HALT: resume wins for one cycle. If halt_req is still high, re-enter HALT on the next cycle.
  - halt_req and a jump in the same RUN cycle: the jump is applied and the state goes to HALT.
- misalign deasserts the cycle after it pulses unless another misaligned jump occurs.

Decomposition:
- Package pc_pkg:
  - pc_state_e enum {PC_RUN, PC_HALT};
  - redirect-source enum {RD_NONE, RD_BRJ, RD_TRAP};
  - function is_aligned(addr, ALIGN_BITS).
- One combinational sub-module, pc_redirect_arb. It takes trap_e/jpe/brch_e/jmp/trap_vec and outputs redirect_en, redirect_target and misalign_det.
- pc_gen holds the registers and the FSM.

Test Plan:
1. Release reset with if_ready=1 and no redirects -> pc 0,4,8,12 on consecutive cycles, pc_next always pc+4.
2. if_ready=0 at pc=8 for 3 cycles, then 1 -> pc holds 8 for 3 cycles, then 12. Repeat with stall=1 instead of if_ready=0 -> same result.
3. At pc=0x10, jpe=1 with jmp=0x100 and trap_e=1 with trap_vec=0x200 in the same cycle -> next pc=0x200, pc_next=0x204. With jpe alone -> pc=0x100, even while stall=1.
4. brch_e=1, jmp=0x102, ALIGN_BITS=2, trap_vec=0x80 -> next pc=0x80, misalign pulses 1 cycle, misalign_addr=0x102. With ALIGN_BITS=1 the same stimulus gives pc=0x102 and no misalign.
5. halt_req at pc=0x20 -> halted=1 and if_valid=0, pc stays 0x20 over 5 cycles. Then resume -> RUN, pc advances to 0x24 next. trap_e in HALT -> pc=trap_vec, halted=0.
6. XLEN=32 with pc forced near the top via jmp=0xFFFF_FFFC -> pc_next=0, next pc=0. Reset asserted mid-stall -> pc=RESET_VEC on the next edge.
